// File: rtl/ps2_cmd_arbiter.sv
// ps2_cmd_arbiter: round-robin owner of the PS/2 command channel.
// Sends 1-2 byte commands, handles FA/FE/timeout, filters ACK bytes.
// Ports: i_clk/i_rstn (sync, active-low); i_req[1:0] with i_cmd*/i_arg*/
//   i_has_arg* per requester; o_done/o_err per-requester pulses; o_busy;
//   o_cmd_val/o_cmd/i_ready to transceiver; i_scan_val/i_scancode from
//   transceiver; o_scan_val/o_scancode to key decoder.
module ps2_cmd_arbiter #(
  parameter int TIMEOUT   = 500000,
  parameter int TW        = 20,
  parameter int MAX_RETRY = 3
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [1:0] i_req,
  input  logic [7:0] i_cmd0,
  input  logic [7:0] i_arg0,
  input  logic       i_has_arg0,
  input  logic [7:0] i_cmd1,
  input  logic [7:0] i_arg1,
  input  logic       i_has_arg1,
  output logic [1:0] o_done,
  output logic [1:0] o_err,
  output logic       o_busy,
  output logic       o_cmd_val,
  output logic [7:0] o_cmd,
  input  logic       i_ready,
  input  logic       i_scan_val,
  input  logic [7:0] i_scancode,
  output logic       o_scan_val,
  output logic [7:0] o_scancode
);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, SEND, WAIT_TX, WAIT_ACK, DONE, ERR
  } state_t;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    R_MAX  = 4'(MAX_RETRY);

  state_t        state, state_d;
  logic          rr, rr_d;
  logic          gnt, gnt_d;
  logic          byte_sel, byte_sel_d;
  logic          has_arg, has_arg_d;
  logic [7:0]    cmd, cmd_d;
  logic [7:0]    arg, arg_d;
  logic [3:0]    retry, retry_d;
  logic [TW-1:0] tmr, tmr_d;

  logic is_fa, is_fe, is_aa, tmo;

  assign is_fa = i_scancode == 8'hFA;
  assign is_fe = i_scancode == 8'hFE;
  assign is_aa = i_scancode == 8'hAA;
  assign tmo   = tmr == T_LAST;

  assign o_scancode = i_scancode;
  assign o_scan_val = i_scan_val &
    ~((state == WAIT_ACK) & (is_fa | is_fe));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state    <= IDLE;
      rr       <= 1'b0;
      gnt      <= 1'b0;
      byte_sel <= 1'b0;
      has_arg  <= 1'b0;
      cmd      <= 8'h00;
      arg      <= 8'h00;
      retry    <= 4'd0;
      tmr      <= '0;
    end else begin
      state    <= state_d;
      rr       <= rr_d;
      gnt      <= gnt_d;
      byte_sel <= byte_sel_d;
      has_arg  <= has_arg_d;
      cmd      <= cmd_d;
      arg      <= arg_d;
      retry    <= retry_d;
      tmr      <= tmr_d;
    end
  end

  always_comb begin
    state_d    = state;
    rr_d       = rr;
    gnt_d      = gnt;
    byte_sel_d = byte_sel;
    has_arg_d  = has_arg;
    cmd_d      = cmd;
    arg_d      = arg;
    retry_d    = retry;
    tmr_d      = tmr;
    o_done     = 2'b00;
    o_err      = 2'b00;
    o_busy     = state != IDLE;
    o_cmd_val  = 1'b0;
    o_cmd      = 8'h00;

    case (state)
      IDLE: begin
        if (|i_req) begin
          // rr names the requester that wins a tie
          gnt_d      = (i_req == 2'b11) ? rr : i_req[1];
          cmd_d      = gnt_d ? i_cmd1 : i_cmd0;
          arg_d      = gnt_d ? i_arg1 : i_arg0;
          has_arg_d  = gnt_d ? i_has_arg1 : i_has_arg0;
          byte_sel_d = 1'b0;
          retry_d    = 4'd0;
          state_d    = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (i_ready) state_d = SEND;
      end
      SEND: begin
        o_cmd_val = 1'b1;
        o_cmd     = byte_sel ? arg : cmd;
        tmr_d     = '0;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        if (!tmo) tmr_d = tmr + 1'b1;
        if (tmo) begin
          if (retry < R_MAX) begin
            retry_d = retry + 4'd1;
            state_d = WAIT_RDY;
          end else begin
            state_d = ERR;
          end
        end else if (tmr != '0 && i_ready) begin
          // tmr==0 marks the cycle right after the strobe
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!tmo) tmr_d = tmr + 1'b1;
        if (i_scan_val) begin
          unique case (1'b1)
            is_fa: begin
              if (!byte_sel && has_arg) begin
                byte_sel_d = 1'b1;
                retry_d    = 4'd0;
                state_d    = WAIT_RDY;
              end else begin
                state_d = DONE;
              end
            end
            is_fe: begin
              if (retry < R_MAX) begin
                retry_d = retry + 4'd1;
                state_d = WAIT_RDY;
              end else begin
                state_d = ERR;
              end
            end
            is_aa: state_d = ERR;
            default: ;
          endcase
        end else if (tmo) begin
          if (retry < R_MAX) begin
            retry_d = retry + 4'd1;
            state_d = WAIT_RDY;
          end else begin
            state_d = ERR;
          end
        end
      end
      DONE: begin
        o_done  = gnt ? 2'b10 : 2'b01;
        rr_d    = ~gnt;
        state_d = IDLE;
      end
      ERR: begin
        o_err   = gnt ? 2'b10 : 2'b01;
        rr_d    = ~gnt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// tb_ps2_cmd_arbiter: directed bench for ps2_cmd_arbiter.
// Small keyboard/transceiver model answers strobes from a reply queue.
module tb_ps2_cmd_arbiter;

  logic       clk = 1'b0;
  logic       i_rstn;
  logic [1:0] i_req;
  logic [7:0] i_cmd0, i_arg0, i_cmd1, i_arg1;
  logic       i_has_arg0, i_has_arg1;
  logic [1:0] o_done, o_err;
  logic       o_busy, o_cmd_val;
  logic [7:0] o_cmd;
  logic       i_ready, i_scan_val;
  logic [7:0] i_scancode;
  logic       o_scan_val;
  logic [7:0] o_scancode;

  always #5 clk = ~clk;

  ps2_cmd_arbiter #(.TIMEOUT(100), .TW(20), .MAX_RETRY(3)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_req(i_req),
    .i_cmd0(i_cmd0), .i_arg0(i_arg0), .i_has_arg0(i_has_arg0),
    .i_cmd1(i_cmd1), .i_arg1(i_arg1), .i_has_arg1(i_has_arg1),
    .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
    .o_cmd_val(o_cmd_val), .o_cmd(o_cmd), .i_ready(i_ready),
    .i_scan_val(i_scan_val), .i_scancode(i_scancode),
    .o_scan_val(o_scan_val), .o_scancode(o_scancode)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int kcnt = 0;
  int idle_cnt = 0;
  logic       inj = 1'b0;
  logic [7:0] inj_code = 8'h00;

  logic [7:0] strb[$];
  int         strb_cyc[$];
  logic [1:0] dn_log[$];
  logic [1:0] er_log[$];
  logic [7:0] rep[$];
  logic [7:0] fwd[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    strb.delete();
    strb_cyc.delete();
    dn_log.delete();
    er_log.delete();
    fwd.delete();
    idle_cnt = 0;
  endtask

  // one cycle: observe outputs, then drive the next inputs
  task automatic step();
    @(negedge clk);
    cyc++;
    if (o_cmd_val) begin
      strb.push_back(o_cmd);
      strb_cyc.push_back(cyc);
    end
    if (o_done != 2'b00) dn_log.push_back(o_done);
    if (o_err != 2'b00) er_log.push_back(o_err);
    if (!o_busy) idle_cnt++;
    i_scan_val = 1'b0;
    if (o_cmd_val) begin
      i_ready = 1'b0;
      kcnt = 5;
    end else if (kcnt > 0) begin
      kcnt--;
      if (kcnt == 2) i_ready = 1'b1;
      if (kcnt == 0 && rep.size() > 0) begin
        i_scan_val = 1'b1;
        i_scancode = rep.pop_front();
      end
    end
    if (inj) begin
      i_scan_val = 1'b1;
      i_scancode = inj_code;
      inj = 1'b0;
    end
    #1;
    if (i_scan_val && o_scan_val) fwd.push_back(i_scancode);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (dn_log.size() + er_log.size() == 0 && n < budget) begin
      step();
      n++;
    end
    chk("ended", 32'(dn_log.size() + er_log.size()), 32'd1);
  endtask

  initial begin
    i_rstn = 1'b0; i_req = 2'b00;
    i_cmd0 = 8'h00; i_arg0 = 8'h00; i_has_arg0 = 1'b0;
    i_cmd1 = 8'h00; i_arg1 = 8'h00; i_has_arg1 = 1'b0;
    i_ready = 1'b1; i_scan_val = 1'b0; i_scancode = 8'h00;
    step();
    step();
    chk("rst_outs",
        {20'd0, o_busy, o_done, o_err, o_cmd_val, o_cmd, o_scan_val},
        32'd0);
    i_rstn = 1'b1;
    step();

    // single-byte FF, answered FA
    clr();
    rep = '{8'hFA};
    i_cmd0 = 8'hFF; i_has_arg0 = 1'b0; i_req = 2'b01;
    wait_end(50);
    i_req = 2'b00;
    chk("s_nstrb", 32'(strb.size()), 32'd1);
    if (strb.size() > 0) chk("s_byte", {24'd0, strb[0]}, 32'hFF);
    chk("s_done", 32'(dn_log.size() > 0 ? dn_log[0] : 2'b00), 32'h1);
    chk("s_fa_filt", 32'(fwd.size()), 32'd0);
    step();
    chk("s_pulse1", {30'd0, o_done}, 32'd0);

    // two-byte ED 02 from requester 1; later input changes ignored
    clr();
    rep = '{8'hFA, 8'hFA};
    i_cmd1 = 8'hED; i_arg1 = 8'h02; i_has_arg1 = 1'b1; i_req = 2'b10;
    step();
    i_cmd1 = 8'h11; i_arg1 = 8'h22; i_has_arg1 = 1'b0;
    wait_end(80);
    i_req = 2'b00;
    chk("d_nstrb", 32'(strb.size()), 32'd2);
    if (strb.size() > 1) begin
      chk("d_b0", {24'd0, strb[0]}, 32'hED);
      chk("d_b1", {24'd0, strb[1]}, 32'h02);
    end
    chk("d_done", 32'(dn_log.size() > 0 ? dn_log[0] : 2'b00), 32'h2);
    chk("d_busy", 32'(idle_cnt), 32'd0);
    step();
    chk("d_idle", {31'd0, o_busy}, 32'd0);

    // resend: FE FE FA
    clr();
    rep = '{8'hFE, 8'hFE, 8'hFA};
    i_cmd0 = 8'hF3; i_has_arg0 = 1'b0; i_req = 2'b01;
    wait_end(120);
    i_req = 2'b00;
    chk("r_nstrb", 32'(strb.size()), 32'd3);
    foreach (strb[k]) chk("r_byte", {24'd0, strb[k]}, 32'hF3);
    chk("r_done", 32'(dn_log.size() > 0 ? dn_log[0] : 2'b00), 32'h1);
    step();

    // four FE replies exhaust the retries
    clr();
    rep = '{8'hFE, 8'hFE, 8'hFE, 8'hFE};
    i_cmd1 = 8'hF3; i_has_arg1 = 1'b0; i_req = 2'b10;
    wait_end(150);
    i_req = 2'b00;
    chk("e_nstrb", 32'(strb.size()), 32'd4);
    chk("e_err", 32'(er_log.size() > 0 ? er_log[0] : 2'b00), 32'h2);
    chk("e_ndone", 32'(dn_log.size()), 32'd0);
    step();

    // timeout with no replies at all
    clr();
    rep.delete();
    i_cmd0 = 8'hF4; i_has_arg0 = 1'b0; i_req = 2'b01;
    wait_end(700);
    i_req = 2'b00;
    chk("t_nstrb", 32'(strb.size()), 32'd4);
    for (int k = 1; k < strb_cyc.size(); k++)
      chk("t_gap", 32'(strb_cyc[k] - strb_cyc[k-1] >= 100), 32'd1);
    chk("t_err", 32'(er_log.size() > 0 ? er_log[0] : 2'b00), 32'h1);
    step();

    // both held: requester 0 was served last, so 1 goes first
    clr();
    rep = '{8'hFA, 8'hFA, 8'hFA, 8'hFA};
    i_cmd0 = 8'hF4; i_cmd1 = 8'hF5;
    i_has_arg0 = 1'b0; i_has_arg1 = 1'b0;
    i_req = 2'b11;
    for (int n = 0; n < 300 && dn_log.size() < 4; n++) step();
    i_req = 2'b00;
    chk("a_ndone", 32'(dn_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < dn_log.size(); k++) begin
      chk("a_done", {30'd0, dn_log[k]}, (k % 2 == 0) ? 32'h2 : 32'h1);
      chk("a_byte", {24'd0, strb[k]}, (k % 2 == 0) ? 32'hF5 : 32'hF4);
    end
    step();

    // FA outside WAIT_ACK is forwarded
    clr();
    inj = 1'b1; inj_code = 8'hFA;
    step();
    chk("p_fa_idle", 32'(fwd.size() > 0 ? fwd[0] : 8'h00), 32'hFA);

    // passthrough of 1D, then AA abort
    clr();
    i_cmd0 = 8'hED; i_has_arg0 = 1'b0; i_req = 2'b01;
    for (int n = 0; n < 20 && strb.size() == 0; n++) step();
    repeat (6) step();
    inj = 1'b1; inj_code = 8'h1D;
    step();
    chk("p_1d_fwd", 32'(fwd.size() > 0 ? fwd[0] : 8'h00), 32'h1D);
    step();
    chk("p_1d_busy", {31'd0, o_busy}, 32'd1);
    chk("p_1d_none", 32'(dn_log.size() + er_log.size()), 32'd0);
    inj = 1'b1; inj_code = 8'hAA;
    wait_end(10);
    i_req = 2'b00;
    chk("p_aa_err", 32'(er_log.size() > 0 ? er_log[0] : 2'b00), 32'h1);
    chk("p_aa_fwd",
        32'(fwd.size() > 1 ? fwd[fwd.size()-1] : 8'h00), 32'hAA);
    step();

    // reset in the middle of WAIT_ACK
    clr();
    i_cmd1 = 8'hED; i_has_arg1 = 1'b0; i_req = 2'b10;
    for (int n = 0; n < 20 && strb.size() == 0; n++) step();
    repeat (6) step();
    chk("x_busy_pre", {31'd0, o_busy}, 32'd1);
    i_rstn = 1'b0; i_req = 2'b00;
    step();
    chk("x_outs",
        {20'd0, o_busy, o_done, o_err, o_cmd_val, o_cmd, o_scan_val},
        32'd0);
    i_rstn = 1'b1; kcnt = 0; i_ready = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
